// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the spi_master transfer-port arbiter.
package spi_arb_pkg;
   localparam int unsigned SPI_DATA_W  = 32;
   localparam int unsigned SPI_NBITS_W = 6;
   localparam int unsigned IDX_W       = 2;   // requester index width, covers NREQ up to 4

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      DONE
   } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit searching upward from last+1, wrapping.
module rr_pick
   import spi_arb_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     winner,
   output logic [IDX_W-1:0] index,
   output logic             found
);

   always_comb begin
      winner = '0;
      index  = '0;
      found  = 1'b0;
      // Scan farthest offset first so the nearest valid requester after last overwrites.
      for (int unsigned k = N; k >= 1; k--) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (valid[j] && (j == (32'(last) + k) % N)) begin
               winner    = '0;
               winner[j] = 1'b1;
               index     = IDX_W'(j);
               found     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master transfer port among NREQ requesters.
// Optional ownership lock for back-to-back transfers: define SPI_ARB_LOCK_EN.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned NBITS_MAX = 32
) (
   input  logic                          clk_in,
   input  logic                          nrst,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [SPI_DATA_W*NREQ-1:0]    req_mosi_data,
   input  logic [SPI_NBITS_W*NREQ-1:0]   req_nbits,
`ifdef SPI_ARB_LOCK_EN
   input  logic [NREQ-1:0]               req_lock,
`endif
   output logic [NREQ-1:0]               req_grant,
   output logic [NREQ-1:0]               req_done,
   output logic [SPI_DATA_W-1:0]         req_miso_data,
   output logic [SPI_DATA_W-1:0]         spi_mosi_data,
   output logic [SPI_NBITS_W-1:0]        spi_nbits,
   output logic                          spi_request,
   input  logic                          spi_ready,
   input  logic [SPI_DATA_W-1:0]         spi_miso_data,
   output logic                          busy
);

   state_t                 state;
   logic [IDX_W-1:0]       last;
   logic [IDX_W-1:0]       owner;
   logic                   issue;
   logic [NREQ-1:0]        pick_valid;
   logic [NREQ-1:0]        pick_onehot;
   logic [IDX_W-1:0]       pick_index;
   logic                   pick_found;
   logic [SPI_DATA_W-1:0]  sel_mosi;
   logic [SPI_NBITS_W-1:0] sel_nbits;
`ifdef SPI_ARB_LOCK_EN
   logic                   lock_q;
   logic                   lock_hold;

   assign lock_hold = |(req_lock & req_grant);
`endif

   rr_pick #(.N(NREQ)) u_pick (
      .valid  (pick_valid),
      .last   (last),
      .winner (pick_onehot),
      .index  (pick_index),
      .found  (pick_found)
   );

   always_comb begin
      pick_valid = req_valid;
`ifdef SPI_ARB_LOCK_EN
      // While locked, only the owner may win; dropping its lock reopens arbitration.
      if (lock_q && lock_hold) pick_valid = req_valid & req_grant;
`endif
      sel_mosi  = '0;
      sel_nbits = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_onehot[i]) begin
            sel_mosi  = req_mosi_data[SPI_DATA_W*i +: SPI_DATA_W];
            sel_nbits = req_nbits[SPI_NBITS_W*i +: SPI_NBITS_W];
         end
      end
   end

   // Request is gated by ready so a master still finishing never sees a request.
   assign spi_request = issue & spi_ready;

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         state         <= IDLE;
         last          <= IDX_W'(NREQ - 1);
         owner         <= '0;
         issue         <= 1'b0;
         req_grant     <= '0;
         req_done      <= '0;
         req_miso_data <= '0;
         spi_mosi_data <= '0;
         spi_nbits     <= '0;
         busy          <= 1'b0;
`ifdef SPI_ARB_LOCK_EN
         lock_q        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef SPI_ARB_LOCK_EN
               if (lock_q && !lock_hold) begin
                  lock_q    <= 1'b0;
                  req_grant <= '0;
               end
`endif
               if (pick_found) begin
                  spi_mosi_data <= sel_mosi;
                  spi_nbits     <= sel_nbits;
                  req_grant     <= pick_onehot;
                  owner         <= pick_index;
                  busy          <= 1'b1;
                  state         <= CHECK;
               end
            end
            CHECK: begin
               if (spi_nbits == '0 || 32'(spi_nbits) > NBITS_MAX) begin
                  req_done      <= req_grant;
                  req_miso_data <= '0;
                  state         <= DONE;
               end else begin
                  issue <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (spi_ready) begin
                  issue <= 1'b0;
                  state <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!spi_ready) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (spi_ready) begin
                  req_done      <= req_grant;
                  req_miso_data <= spi_miso_data;
                  state         <= DONE;
               end
            end
            DONE: begin
               req_done      <= '0;
               req_miso_data <= '0;
               last          <= owner;
               busy          <= 1'b0;
               state         <= IDLE;
`ifdef SPI_ARB_LOCK_EN
               if (lock_hold) begin
                  lock_q <= 1'b1;
               end else begin
                  lock_q    <= 1'b0;
                  req_grant <= '0;
               end
`else
               req_grant <= '0;
`endif
            end
            default: begin
               state     <= IDLE;
               issue     <= 1'b0;
               req_grant <= '0;
               req_done  <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
